// File: rtl/mem_bus_pkg.sv
// Shared types and default region map for the CPU-to-slave memory router.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_UNMAPPED = 2'd1,
    ERR_CONFLICT = 2'd2,
    ERR_TIMEOUT  = 2'd3
  } err_code_t;

  localparam logic [23:0] FLASH_BASE = 24'h000000;
  localparam logic [23:0] FLASH_MASK = 24'hE00000;
  localparam logic [23:0] DRAM_BASE  = 24'h200000;
  localparam logic [23:0] DRAM_MASK  = 24'hE00000;
  localparam logic [23:0] SRAM_BASE  = 24'h400000;
  localparam logic [23:0] SRAM_MASK  = 24'hFF0000;
  localparam logic [23:0] LED_BASE   = 24'hFF0000;
  localparam logic [23:0] LED_MASK   = 24'hFF0000;

  // Channel 0 sits in the low bits, matching the packed CH_BASE/CH_MASK layout.
  localparam logic [95:0] DEFAULT_BASE = {LED_BASE, SRAM_BASE, DRAM_BASE, FLASH_BASE};
  localparam logic [95:0] DEFAULT_MASK = {LED_MASK, SRAM_MASK, DRAM_MASK, FLASH_MASK};

endpackage

// File: rtl/mem_region_decode.sv
// Combinational base/mask region decoder; the lowest-index matching channel wins.
module mem_region_decode #(
  parameter int                       N_CH   = 4,
  parameter int                       ADDR_W = 24,
  parameter logic [N_CH*ADDR_W-1:0]   BASE   = '0,
  parameter logic [N_CH*ADDR_W-1:0]   MASK   = '0,
  localparam int                      CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic              hit_o,
  output logic [CH_W-1:0]   ch_idx_o
);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    hit_o    = 1'b0;
    ch_idx_o = '0;
    // Scan downwards so the last (lowest-index) match overwrites the others.
    for (int i = N_CH - 1; i >= 0; i--) begin
      if ((addr_i & MASK[i*ADDR_W +: ADDR_W]) ==
          (BASE[i*ADDR_W +: ADDR_W] & MASK[i*ADDR_W +: ADDR_W])) begin
        hit_o    = 1'b1;
        ch_idx_o = CH_W'(i);
      end
    end
  end

endmodule

// File: rtl/mem_bus_router.sv
// Single-master router: decodes CPU accesses onto N slave channels with
// per-channel wait states, a watchdog, and a sticky first-error status.
module mem_bus_router
  import mem_bus_pkg::*;
#(
  parameter int                     N_CH    = 4,
  parameter int                     ADDR_W  = 24,
  parameter int                     DATA_W  = 16,
  parameter logic [N_CH*ADDR_W-1:0] CH_BASE = '0,
  parameter logic [N_CH*ADDR_W-1:0] CH_MASK = '0,
  parameter logic [N_CH*4-1:0]      CH_WAIT = '0,
  parameter int                     TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_W-1:0]      addr_i,
  input  logic                   re_i,
  input  logic                   we_i,
  input  logic [DATA_W-1:0]      wdata_i,
  output logic [DATA_W-1:0]      rdata_o,
  output logic                   needWait_o,
  output logic [N_CH-1:0]        ch_sel_o,
  output logic [ADDR_W-1:0]      ch_addr_o,
  output logic                   ch_re_o,
  output logic                   ch_we_o,
  output logic [DATA_W-1:0]      ch_wdata_o,
  input  logic [N_CH*DATA_W-1:0] ch_rdata_i,
  input  logic [N_CH-1:0]        ch_wait_i,
  output logic                   err_o,
  output logic [1:0]             err_code_o,
  output logic [ADDR_W-1:0]      err_addr_o,
  input  logic                   err_clr_i
);

  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t            r_state, w_next;
  logic [CH_W-1:0]   r_ch, w_dec_idx;
  logic              w_dec_hit;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr, r_err_addr;
  logic [DATA_W-1:0] r_wdata, r_rdata;
  logic [CNT_W-1:0]  r_wait_cnt, r_to_cnt;
  logic              r_err;
  err_code_t         r_err_code;

  logic              w_req, w_start, w_bad, w_complete, w_timeout, w_access;
  logic              w_err_set;
  err_code_t         w_err_code;
  logic [ADDR_W-1:0] w_err_addr;

  mem_region_decode #(
    .N_CH   (N_CH),
    .ADDR_W (ADDR_W),
    .BASE   (CH_BASE),
    .MASK   (CH_MASK)
  ) u_decode (
    .addr_i   (addr_i),
    .hit_o    (w_dec_hit),
    .ch_idx_o (w_dec_idx)
  );

  assign w_req      = re_i | we_i;
  assign w_access   = (r_state == ACCESS);
  assign w_start    = (r_state == IDLE) && w_req;
  assign w_bad      = w_start && (!w_dec_hit || (re_i && we_i));
  assign w_complete = w_access && (r_wait_cnt == '0) && !ch_wait_i[r_ch];
  assign w_timeout  = w_access && !w_complete && (r_to_cnt == CNT_W'(TIMEOUT - 1));

  // NOTE: state and datapath registers use non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_next = w_bad ? DONE : ACCESS;
      // A request dropped mid-access skips DONE so the next one is taken at once.
      ACCESS:  if (w_complete || w_timeout) w_next = w_req ? DONE : IDLE;
      DONE:    if (!w_req) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ch       <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_wait_cnt <= '0;
      r_to_cnt   <= '0;
    end else begin
      if (w_start) begin
        r_ch       <= w_dec_idx;
        r_we       <= we_i;
        r_addr     <= addr_i;
        r_wdata    <= wdata_i;
        r_wait_cnt <= CNT_W'(CH_WAIT[w_dec_idx*4 +: 4]);
        r_to_cnt   <= '0;
        if (w_bad) r_rdata <= '1;
      end
      if (w_access) begin
        if (r_wait_cnt != '0) r_wait_cnt <= r_wait_cnt - CNT_W'(1);
        r_to_cnt <= r_to_cnt + CNT_W'(1);
        if (w_complete && !r_we) r_rdata <= ch_rdata_i[r_ch*DATA_W +: DATA_W];
        if (w_timeout)           r_rdata <= '1;
      end
    end
  end

  assign w_err_set  = w_bad || w_timeout;
  assign w_err_code = w_timeout ? ERR_TIMEOUT : ((re_i && we_i) ? ERR_CONFLICT : ERR_UNMAPPED);
  assign w_err_addr = w_timeout ? r_addr : addr_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
      r_err_addr <= '0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
      if (!r_err) begin
        r_err_code <= w_err_code;
        r_err_addr <= w_err_addr;
      end
    end else if (err_clr_i) begin
      r_err <= 1'b0;
    end
  end

  // Gated by rst so the CPU stall also drops while reset is held.
  assign needWait_o = !rst && w_req && (r_state != DONE);
  assign ch_sel_o   = w_access ? (N_CH'(1) << r_ch) : '0;
  assign ch_re_o    = w_access && !r_we;
  assign ch_we_o    = w_access && r_we;
  assign ch_addr_o  = r_addr;
  assign ch_wdata_o = r_wdata;
  assign rdata_o    = r_rdata;
  assign err_o      = r_err;
  assign err_code_o = r_err_code;
  assign err_addr_o = r_err_addr;

endmodule

// File: tb/tb_mem_bus_router.sv
// Self-checking bench for mem_bus_router: directed scenarios plus random
// transactions checked cycle by cycle against a transaction-level model.
module tb_mem_bus_router;

  localparam int TIMEOUT = 16;
  localparam logic [95:0] P_BASE = {24'hFF0000, 24'h400000, 24'h200000, 24'h000000};
  localparam logic [95:0] P_MASK = {24'hFF0000, 24'hFF0000, 24'hE00000, 24'hE00000};
  localparam logic [15:0] P_WAIT = {4'd0, 4'd1, 4'd3, 4'd2};

  localparam logic [23:0] RB [4] = '{24'h000000, 24'h200000, 24'h400000, 24'hFF0000};
  localparam logic [23:0] RM [4] = '{24'hE00000, 24'hE00000, 24'hFF0000, 24'hFF0000};
  localparam int          WAITS [4] = '{2, 3, 1, 0};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] addr_i = '0;
  logic        re_i = 1'b0, we_i = 1'b0;
  logic [15:0] wdata_i = '0;
  logic [15:0] rdata_o;
  logic        needWait_o;
  logic [3:0]  ch_sel_o;
  logic [23:0] ch_addr_o;
  logic        ch_re_o, ch_we_o;
  logic [15:0] ch_wdata_o;
  logic [63:0] ch_rdata_i = '0;
  logic [3:0]  ch_wait_i = '0;
  logic        err_o;
  logic [1:0]  err_code_o;
  logic [23:0] err_addr_o;
  logic        err_clr_i = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  // Transaction-level expectations
  logic [15:0] m_rdata = '0;
  logic        m_err   = 1'b0;
  int          m_code  = 0;
  logic [23:0] m_addr  = '0;

  always #5 clk = ~clk;

  mem_bus_router #(
    .N_CH(4), .ADDR_W(24), .DATA_W(16),
    .CH_BASE(P_BASE), .CH_MASK(P_MASK), .CH_WAIT(P_WAIT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .addr_i(addr_i), .re_i(re_i), .we_i(we_i),
    .wdata_i(wdata_i), .rdata_o(rdata_o), .needWait_o(needWait_o),
    .ch_sel_o(ch_sel_o), .ch_addr_o(ch_addr_o), .ch_re_o(ch_re_o),
    .ch_we_o(ch_we_o), .ch_wdata_o(ch_wdata_o), .ch_rdata_i(ch_rdata_i),
    .ch_wait_i(ch_wait_i), .err_o(err_o), .err_code_o(err_code_o),
    .err_addr_o(err_addr_o), .err_clr_i(err_clr_i)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int decode(input logic [23:0] a);
    for (int i = 0; i < 4; i++)
      if ((a & RM[i]) == (RB[i] & RM[i])) return i;
    return -1;
  endfunction

  task automatic err_event(input logic [23:0] a, input int code);
    if (!m_err) begin
      m_code = code;
      m_addr = a;
    end
    m_err = 1'b1;
  endtask

  task automatic check_status(input string tag);
    check({tag, "_rdata"},    rdata_o,    m_rdata);
    check({tag, "_err"},      err_o,      m_err);
    check({tag, "_err_code"}, err_code_o, m_code);
    check({tag, "_err_addr"}, err_addr_o, m_addr);
  endtask

  // One CPU transaction: s = slave-wait cycles at the start of the access,
  // hold = extra cycles the request stays up after the stall ends.
  task automatic run_txn(input logic [23:0] a, input logic r, input logic w,
                         input logic [15:0] wd, input logic [15:0] sd,
                         input int s, input int hold, input logic clr,
                         input logic first_now);
    int ch, acc, mx;
    logic bad, tmo, in_acc;
    logic [3:0] oh;
    ch  = decode(a);
    bad = (r && w) || (ch < 0);
    tmo = 1'b0;
    acc = 0;
    oh  = '0;
    if (!bad) begin
      mx = (WAITS[ch] > s) ? WAITS[ch] : s;
      if (mx > TIMEOUT - 1) begin
        acc = TIMEOUT;
        tmo = 1'b1;
      end else begin
        acc = mx + 1;
      end
      oh = 4'(1 << ch);
    end
    if (bad) begin
      err_event(a, (r && w) ? 2 : 1);
      m_rdata = 16'hFFFF;
    end else if (clr) begin
      m_err = 1'b0;
    end
    if (tmo) begin
      err_event(a, 3);
      m_rdata = 16'hFFFF;
    end else if (!bad && r) begin
      m_rdata = sd;
    end

    for (int c = 0; c <= acc + hold; c++) begin
      if (!(first_now && c == 0)) @(negedge clk);
      if (c == 0) begin
        addr_i    = a;
        re_i      = r;
        we_i      = w;
        wdata_i   = wd;
        err_clr_i = clr;
        ch_rdata_i = {$urandom, $urandom};
        if (!bad) ch_rdata_i[ch*16 +: 16] = sd;
      end else begin
        err_clr_i = 1'b0;
      end
      ch_wait_i = 4'($urandom);
      if (!bad) ch_wait_i[ch] = (c >= 1) && (c - 1 < s);
      #1;
      in_acc = (c >= 1) && (c <= acc);
      check("needWait", needWait_o, c <= acc);
      check("ch_re",    ch_re_o,    in_acc && !w);
      check("ch_we",    ch_we_o,    in_acc && w);
      check("ch_sel",   ch_sel_o,   in_acc ? oh : 4'b0);
      if (in_acc) begin
        check("ch_addr", ch_addr_o, a);
        if (w) check("ch_wdata", ch_wdata_o, wd);
      end
    end
    @(negedge clk);
    re_i      = 1'b0;
    we_i      = 1'b0;
    err_clr_i = 1'b0;
    #1;
    check("done_needWait", needWait_o, 1'b0);
    check("done_sel",      ch_sel_o,   4'b0);
    @(negedge clk);
    #1;
    check_status("txn");
  endtask

  task automatic clear_err();
    @(negedge clk);
    err_clr_i = 1'b1;
    @(negedge clk);
    err_clr_i = 1'b0;
    m_err = 1'b0;
    #1;
    check("err_clr", err_o, 1'b0);
  endtask

  initial begin
    logic [23:0] a;
    logic        r, w;
    int          kind, op, s;

    repeat (2) @(negedge clk);
    #1;
    check("rst_needWait", needWait_o, 1'b0);
    check("rst_sel",      ch_sel_o,   4'b0);
    check("rst_re",       ch_re_o,    1'b0);
    check("rst_we",       ch_we_o,    1'b0);
    check("rst_ch_addr",  ch_addr_o,  24'h0);
    check("rst_ch_wdata", ch_wdata_o, 16'h0);
    check_status("rst");
    rst = 1'b0;

    // Flash read, 2 wait states: stall 4 cycles, strobe 3 cycles
    run_txn(24'h000010, 1'b1, 1'b0, 16'h0, 16'hBEEF, 0, 0, 1'b0, 1'b0);
    // LED write, no wait states
    run_txn(24'hFF0000, 1'b0, 1'b1, 16'h1234, 16'h0, 0, 0, 1'b0, 1'b0);
    // Unmapped read
    run_txn(24'h800000, 1'b1, 1'b0, 16'h0, 16'h0, 0, 0, 1'b0, 1'b0);
    clear_err();
    // SRAM read with slave stuck waiting -> watchdog abort
    run_txn(24'h400020, 1'b1, 1'b0, 16'h0, 16'h1111, 40, 0, 1'b0, 1'b0);
    // Second error keeps the first error's code and address
    run_txn(24'h900000, 1'b1, 1'b0, 16'h0, 16'h0, 0, 0, 1'b0, 1'b0);
    clear_err();
    // Held request across DONE, then a re&we conflict
    run_txn(24'h000040, 1'b1, 1'b0, 16'h0, 16'hCAFE, 1, 5, 1'b0, 1'b0);
    run_txn(24'h000020, 1'b1, 1'b1, 16'h0, 16'h0, 0, 0, 1'b0, 1'b0);
    // New error in the same cycle as a clear: error wins, first one kept
    run_txn(24'h800004, 1'b1, 1'b0, 16'h0, 16'h0, 0, 0, 1'b1, 1'b0);
    clear_err();

    // Request dropped mid-access: access completes, next request taken at once
    @(negedge clk);
    addr_i     = 24'h200040;
    re_i       = 1'b1;
    we_i       = 1'b0;
    ch_wait_i  = 4'b0;
    ch_rdata_i = {16'h1111, 16'h2222, 16'h5A5A, 16'h4444};
    #1;
    check("drop_needWait", needWait_o, 1'b1);
    @(negedge clk);
    re_i = 1'b0;
    #1;
    check("drop_re_first", ch_re_o, 1'b1);
    repeat (3) @(negedge clk);
    #1;
    check("drop_re_last", ch_re_o, 1'b1);
    @(negedge clk);
    #1;
    check("drop_re_off", ch_re_o, 1'b0);
    check("drop_rdata",  rdata_o, 16'h5A5A);
    m_rdata = 16'h5A5A;
    run_txn(24'h000100, 1'b1, 1'b0, 16'h0, 16'h7777, 1, 0, 1'b0, 1'b1);

    // Reset in the middle of a stalled access
    run_txn(24'h900000, 1'b0, 1'b1, 16'h0, 16'h0, 0, 0, 1'b0, 1'b0);
    @(negedge clk);
    addr_i    = 24'h200100;
    re_i      = 1'b1;
    we_i      = 1'b0;
    ch_wait_i = 4'hF;
    repeat (2) @(negedge clk);
    #1;
    check("pre_rst_re", ch_re_o, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_re",       ch_re_o,    1'b0);
    check("mid_rst_sel",      ch_sel_o,   4'b0);
    check("mid_rst_needWait", needWait_o, 1'b0);
    check("mid_rst_ch_addr",  ch_addr_o,  24'h0);
    m_rdata = '0;
    m_err   = 1'b0;
    m_code  = 0;
    m_addr  = '0;
    check_status("mid_rst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_txn(24'h200100, 1'b1, 1'b0, 16'h0, 16'hC0DE, 0, 0, 1'b0, 1'b1);

    // Random traffic
    for (int t = 0; t < 200; t++) begin
      kind = $urandom_range(0, 4);
      if (kind < 4) a = RB[kind] | (24'($urandom) & ~RM[kind]);
      else          a = 24'($urandom);
      op = $urandom_range(0, 9);
      r  = (op <= 5);
      w  = (op == 0) || (op >= 6);
      s  = ($urandom_range(0, 19) > 17) ? 20 : $urandom_range(0, 4);
      run_txn(a, r, w, 16'($urandom), 16'($urandom), s,
              $urandom_range(0, 2), ($urandom_range(0, 3) == 0), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_router.md
# mem_bus_router

Parametrised single-master memory router that sits between the CPU bus (`addr`/`re`/`we`/`needWait`) and N slave channels (flash, DRAM, SRAM, LED/peripheral RAM, …).
- Each transaction is decoded against per-channel base/mask regions and steered to exactly one channel.
- The block inserts a per-channel minimum wait-state count and honours each slave's wait line.
- A watchdog aborts hung accesses.
- The block latches an error status for unmapped, conflicting or timed-out accesses.

## Interface
Parameters:
- `N_CH`, 4: number of slave channels (1–8).
- `ADDR_W`, 24: address width.
- `DATA_W`, 16: data width.
- `CH_BASE`, `{N_CH{ADDR_W}}` packed, 0: region base per channel (channel i in bits `[i*ADDR_W +: ADDR_W]`).
- `CH_MASK`, packed, 0: address bits compared per channel. A hit requires `(addr & MASK) == (BASE & MASK)`.
- `CH_WAIT`, `{N_CH{4}}` packed, 0: minimum wait cycles per channel (0–15).
- `TIMEOUT`, 255: maximum cycles in `ACCESS` before abort (≥ 16).

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `addr_i` in `ADDR_W`: CPU address.
- `re_i` in 1: CPU read request.
- `we_i` in 1: CPU write request.
- `wdata_i` in `DATA_W`: CPU write data.
- `rdata_o` out `DATA_W`: read data to CPU.
- `needWait_o` out 1: CPU stall.
- `ch_sel_o` out `N_CH`: one-hot channel select.
- `ch_addr_o` out `ADDR_W`: latched address.
- `ch_re_o` out 1: read strobe, qualified by `ch_sel_o`.
- `ch_we_o` out 1: write strobe, qualified by `ch_sel_o`.
- `ch_wdata_o` out `DATA_W`: latched write data.
- `ch_rdata_i` in `N_CH*DATA_W`: per-channel read data.
- `ch_wait_i` in `N_CH`: per-channel stall.
- `err_o` out 1: sticky error flag.
- `err_code_o` out 2: 1 = unmapped, 2 = re&we conflict, 3 = timeout.
- `err_addr_o` out `ADDR_W`: address of the first error.
- `err_clr_i` in 1: clears the error status.

## Operation
FSM states: `IDLE`, `ACCESS`, `DONE`.

- **IDLE**
  - Trigger: on `re_i|we_i`, latch `addr_i`, `wdata_i`, the op and the decoded channel. Decode picks the lowest-index hit.
  - Hit, exactly one of `re_i`/`we_i`: go to `ACCESS`. Load `wait_cnt = CH_WAIT[ch]` and `to_cnt = 0`.
  - No hit, or `re_i&we_i`: go to `DONE` with error. `rdata_o = {DATA_W{1'b1}}`. No channel strobe.
- **ACCESS**
  - Outputs: `ch_sel_o`, strobe, `ch_addr_o` and `ch_wdata_o` are driven from registers.
  - Counters: `wait_cnt` decrements to 0 and saturates there. `to_cnt` increments every cycle.
  - Completion: when `wait_cnt==0 && !ch_wait_i[ch]`, capture `ch_rdata_i[ch]` into `rdata_o` (reads only; writes leave `rdata_o` unchanged) and go to `DONE`.
  - Timeout: when `to_cnt == TIMEOUT-1` before completion, abort. Error code 3, `rdata_o` = all ones, go to `DONE`.
- **DONE**
  - Strobes and selects are low.
  - Go to `IDLE` once `re_i` and `we_i` are both low. A held request is never re-issued.
- **Error status**
  - Set: an error sets `err_o`. `err_code_o`/`err_addr_o` load only when `err_o` was 0, so the first error wins.
  - Clear: `err_clr_i` clears `err_o`. A new error in the same cycle as `err_clr_i` takes precedence.
- **Arithmetic:** counters are unsigned, width `$clog2(TIMEOUT+1)`. Decode compares full `ADDR_W`.

## Timing
- **Reset values:** state `IDLE`; `rdata_o` 0; `ch_sel_o` 0; `ch_re_o`/`ch_we_o` 0; `ch_addr_o`/`ch_wdata_o` 0; `err_o` 0; `err_code_o` 0; `err_addr_o` 0.
- **needWait_o:** combinational, `(re_i|we_i) && state != DONE`. It is high in the request cycle itself.
- **Latency:** a hit with `CH_WAIT=w` and no slave wait takes `w+1` cycles in `ACCESS`, so `needWait_o` is high for `w+2` cycles. Each slave-wait cycle adds 1. Unmapped and conflict accesses stall 1 cycle.
- **Slave handshake:** slaves see stable addr/data for the whole `ACCESS`. They must present `rdata` in the cycle `ch_wait_i` is low.
- **Reset mid-transaction:** strobes drop immediately (asynchronous); FSM goes to `IDLE`. A CPU request still asserted after reset starts a fresh access.
- **Request drop:** if `re_i`/`we_i` drops during `ACCESS`, the access still completes, then the FSM goes straight to `IDLE`.

## Structure
- Package `mem_bus_pkg`:
  - `typedef enum logic [1:0] {IDLE, ACCESS, DONE}`.
  - `err_code` enum.
  - Localparams for default region maps: flash `0x000000/0xE00000`, DRAM, SRAM, LEDs.
- Sub-module `mem_region_decode`: combinational, parametrised by `N_CH`/`BASE`/`MASK`. Outputs `hit` and `ch_idx`.
- The router instantiates it once. Top-level glue handles the tristate `data_io`.

## Test plan
- **Read, flash channel:** `CH_WAIT[0]=2`, read `0x000010`, slave returns `0xBEEF`. Expect `needWait_o` high 4 cycles, `rdata_o=0xBEEF`, `ch_re_o` high 3 cycles.
- **Write, LED channel:** `CH_WAIT=0`, write `0x1234` to `0xFF0000`. Expect `ch_we_o` for 1 cycle, `ch_wdata_o=0x1234`, `needWait_o` high 2 cycles, no error.
- **Unmapped read:** read `0x800000`. Expect `rdata_o=0xFFFF`, `err_o=1`, `err_code_o=1`, `err_addr_o=0x800000`, no `ch_sel_o` bit.
- **Slave timeout:** `TIMEOUT=16`, `ch_wait_i` stuck high. Expect abort after 16 `ACCESS` cycles, `err_code_o=3`, strobe drops. A second error leaves `err_addr_o` unchanged; `err_clr_i` clears `err_o`.
- **Held request, re&we conflict:** hold `re_i` across `DONE` for 5 cycles. Expect a single `ch_re_o` burst. Then assert `re_i&we_i`: expect `err_code_o=2`.
- **Reset mid-access:** assert `rst` while in `ACCESS` with `ch_wait_i` high. Expect all outputs 0 in the same cycle and state `IDLE`; the access restarts after `rst` release.
